// File: rtl/sha_pkg.sv
// SHA-256 constants and round helper functions shared by the nonce-tester core.
package sha_pkg;

    typedef logic [31:0] word_t;

    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam word_t K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t small_sigma0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t small_sigma1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic word_t byteswap32(input word_t x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

endpackage

// File: rtl/sha_core_top_if.sv
// Host/controller-facing signal bundle of the nonce-tester core.
interface sha_core_top_if;
    logic         solveEn;
    logic [255:0] midState;
    logic [511:0] headData;
    logic [31:0]  nonce;
    logic [31:0]  nonceFactor;
    logic [5:0]   cycle;
    logic [255:0] shaOutput;
    logic [32:0]  coreOutput;

    modport master (
        output solveEn, midState, headData, nonce, nonceFactor,
        input  cycle, shaOutput, coreOutput
    );

    modport slave (
        input  solveEn, midState, headData, nonce, nonceFactor,
        output cycle, shaOutput, coreOutput
    );
endinterface

// File: rtl/cycle_counter.sv
// Round index 0..63; wraps naturally and freezes while solveEn is low.
module cycle_counter (
    input  logic       clk,
    input  logic       clearCounter,
    input  logic       solveEn,
    output logic [5:0] cycle
);
    logic [5:0] cnt_q, cnt_d;

    always_comb cnt_d = cnt_q + 6'd1;

    always_ff @(posedge clk) begin
        if (clearCounter)
            cnt_q <= 6'd0;
        else if (solveEn)
            cnt_q <= cnt_d;
    end

    assign cycle = cnt_q;
endmodule

// File: rtl/sha_core_top.sv
// Iterative double-SHA-256 nonce tester: one round per enabled clock, pass 1 from the
// midstate with the nonce inserted, pass 2 over the pass-1 digest from the standard IV.
module sha_core_top
    import sha_pkg::*;
(
    input  logic           clk,
    input  logic           clearCounter,
    sha_core_top_if.slave  bus
);
    logic [5:0]   cycle;
    logic         phase_q;
    logic [31:0]  nonce_q;
    logic [255:0] init_q;
    logic [255:0] hash_q;
    logic [32:0]  core_q;
    word_t        v_q [8];
    word_t        w_q [16];

    logic         first, last;
    logic [31:0]  n_eff;
    logic [255:0] init_sel;
    logic [255:0] sum_d;
    word_t        msg [16];
    word_t        vin [8];
    word_t        win [16];
    word_t        v_d [8];
    word_t        w_d [16];
    word_t        t1, t2, w_new;

    cycle_counter u_cycle_counter (
        .clk          (clk),
        .clearCounter (clearCounter),
        .solveEn      (bus.solveEn),
        .cycle        (cycle)
    );

    always_comb begin
        first    = (cycle == 6'd0);
        last     = (cycle == 6'd63);
        n_eff    = bus.nonce + bus.nonceFactor;
        init_sel = phase_q ? SHA_IV : bus.midState;

        // Pass 2 block is the 256-bit pass-1 digest with fixed padding for a 256-bit message.
        for (int i = 0; i < 16; i++) begin
            msg[i] = 32'h0;
            if (!phase_q)
                msg[i] = (i == 3) ? byteswap32(n_eff) : bus.headData[32*i +: 32];
            else if (i < 8)
                msg[i] = hash_q[255-32*i -: 32];
            else if (i == 8)
                msg[i] = 32'h80000000;
            else if (i == 15)
                msg[i] = 32'h00000100;
        end

        for (int i = 0; i < 8; i++)
            vin[i] = first ? init_sel[255-32*i -: 32] : v_q[i];
        for (int i = 0; i < 16; i++)
            win[i] = first ? msg[i] : w_q[i];

        t1 = vin[7] + big_sigma1(vin[4]) + ch(vin[4], vin[5], vin[6]) + K[cycle] + win[0];
        t2 = big_sigma0(vin[0]) + maj(vin[0], vin[1], vin[2]);

        v_d[0] = t1 + t2;
        v_d[1] = vin[0];
        v_d[2] = vin[1];
        v_d[3] = vin[2];
        v_d[4] = vin[3] + t1;
        v_d[5] = vin[4];
        v_d[6] = vin[5];
        v_d[7] = vin[6];

        w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];
        for (int i = 0; i < 15; i++)
            w_d[i] = win[i+1];
        w_d[15] = w_new;

        // init_q already holds this pass's chaining value by round 63.
        sum_d = '0;
        for (int i = 0; i < 8; i++)
            sum_d[255-32*i -: 32] = init_q[255-32*i -: 32] + v_d[i];
    end

    always_ff @(posedge clk) begin
        if (clearCounter) begin
            phase_q <= 1'b0;
            nonce_q <= '0;
            init_q  <= '0;
            hash_q  <= '0;
            core_q  <= '0;
            v_q     <= '{default: '0};
            w_q     <= '{default: '0};
        end else if (bus.solveEn) begin
            v_q <= v_d;
            w_q <= w_d;
            if (first)
                init_q <= init_sel;
            if (first && !phase_q)
                nonce_q <= n_eff;
            if (last) begin
                hash_q  <= sum_d;
                phase_q <= ~phase_q;
                if (phase_q)
                    core_q <= {(sum_d[31:0] == 32'h0), nonce_q};
            end
        end
    end

    assign bus.cycle      = cycle;
    assign bus.shaOutput  = hash_q;
    assign bus.coreOutput = core_q;
endmodule

// File: tb/tb_sha_core_top.sv
// Directed-sequence bench for sha_core_top against a plain double-SHA-256 model.
module tb_sha_core_top;
    logic clk = 1'b0;
    logic clearCounter;
    always #5 clk = ~clk;

    sha_core_top_if bus ();

    sha_core_top dut (
        .clk          (clk),
        .clearCounter (clearCounter),
        .bus          (bus)
    );

    int total = 0;
    int bad   = 0;

    localparam logic [255:0] IV_M =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic [31:0] KM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Textbook SHA-256 compression: full 64-word expansion, then 64 rounds.
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, s0, s1, t1, t2;
        logic [255:0] hout;
        for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KM[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        hout = {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e,  hin[95:64] + f,   hin[63:32] + g,    hin[31:0] + h};
        return hout;
    endfunction

    task automatic model(input logic [255:0] mid, input logic [511:0] head, input logic [31:0] n,
                         output logic [255:0] p1, output logic [255:0] p2);
        logic [511:0] b1, b2;
        b1 = head;
        b1[127:96] = bswap(n);
        p1 = compress(mid, b1);
        b2 = '0;
        for (int i = 0; i < 8; i++) b2[32*i +: 32] = p1[255-32*i -: 32];
        b2[287:256] = 32'h80000000;
        b2[511:480] = 32'h00000100;
        p2 = compress(IV_M, b2);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clearCounter = 1'b1;
        step(1);
        clearCounter = 1'b0;
    endtask

    task automatic rand_vec(output logic [255:0] mid, output logic [511:0] head,
                            output logic [31:0] n, output logic [31:0] f);
        for (int k = 0; k < 8; k++) mid[32*k +: 32] = $urandom();
        for (int k = 0; k < 16; k++) head[32*k +: 32] = $urandom();
        n = $urandom();
        f = $urandom();
    endtask

    task automatic apply(input logic [255:0] mid, input logic [511:0] head,
                         input logic [31:0] n, input logic [31:0] f);
        bus.midState    = mid;
        bus.headData    = head;
        bus.nonce       = n;
        bus.nonceFactor = f;
    endtask

    logic [255:0] midA, mid, p1, p2, p1A, p2A, prev_core;
    logic [511:0] headA, head, abc;
    logic [31:0]  n, f, nsum;

    initial begin
        clearCounter    = 1'b0;
        bus.solveEn     = 1'b0;
        bus.midState    = '0;
        bus.headData    = '0;
        bus.nonce       = '0;
        bus.nonceFactor = '0;

        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        check("model_abc", compress(IV_M, abc),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        check("nonce_bswap", bswap(32'd411342221), 32'h8d958418);

        // Reset with solveEn high: reset must win.
        midA  = 256'h283048996015d72e781f50c06df10eb3bda2b4ea48f552d85a018aef1e397ddc;
        headA = '0;
        headA[31:0]    = 32'h7dab00c4;
        headA[63:32]   = 32'h76167e54;
        headA[95:64]   = 32'h61481b18;
        headA[159:128] = 32'h80000000;
        headA[511:480] = 32'h00000280;
        apply(midA, headA, 32'd411342221, 32'd0);
        bus.solveEn = 1'b1;
        do_reset();
        check("rst_cycle", bus.cycle, 0);
        check("rst_sha", bus.shaOutput, 0);
        check("rst_core", bus.coreOutput, 0);

        model(midA, headA, 32'd411342221, p1A, p2A);
        for (int i = 1; i <= 64; i++) begin
            step(1);
            check($sformatf("cycle_%0d", i), bus.cycle, i % 64);
        end
        check("A_pass1", bus.shaOutput, p1A);
        check("A_core_hold0", bus.coreOutput, 0);
        step(64);
        check("A_pass2", bus.shaOutput, p2A);
        check("A_core", bus.coreOutput, {(p2A[31:0] == 32'h0), 32'h1884958D});

        // Same effective nonce via the per-core offset.
        apply(midA, headA, 32'd411342220, 32'd1);
        do_reset();
        step(128);
        check("off_sha", bus.shaOutput, p2A);
        check("off_nonce", bus.coreOutput[31:0], 32'h1884958D);
        check("off_golden", bus.coreOutput[32], (p2A[31:0] == 32'h0));

        // Freeze at round 20 of pass 2; disturb inputs while frozen.
        rand_vec(mid, head, n, f);
        nsum = n + f;
        model(mid, head, nsum, p1, p2);
        apply(mid, head, n, f);
        do_reset();
        step(84);
        check("frz_cycle_pre", bus.cycle, 20);
        check("frz_sha_pre", bus.shaOutput, p1);
        bus.solveEn = 1'b0;
        bus.nonce = ~n;
        bus.headData = ~head;
        step(5);
        check("frz_cycle", bus.cycle, 20);
        check("frz_sha", bus.shaOutput, p1);
        bus.solveEn = 1'b1;
        step(44);
        check("frz_final", bus.shaOutput, p2);
        check("frz_core", bus.coreOutput, {(p2[31:0] == 32'h0), nsum});
        prev_core = {223'd0, (p2[31:0] == 32'h0), nsum};

        // Back-to-back pass, then reset at round 40 of pass 2.
        rand_vec(mid, head, n, f);
        nsum = n + f;
        model(mid, head, nsum, p1, p2);
        apply(mid, head, n, f);
        step(64);
        check("b2b_pass1", bus.shaOutput, p1);
        step(40);
        check("mid_cycle", bus.cycle, 40);
        check("mid_core_hold", bus.coreOutput, prev_core);
        do_reset();
        check("mid_rst_cycle", bus.cycle, 0);
        check("mid_rst_sha", bus.shaOutput, 0);
        check("mid_rst_core", bus.coreOutput, 0);
        step(128);
        check("rerun_sha", bus.shaOutput, p2);
        check("rerun_core", bus.coreOutput, {(p2[31:0] == 32'h0), nsum});

        for (int r = 0; r < 3; r++) begin
            rand_vec(mid, head, n, f);
            nsum = n + f;
            model(mid, head, nsum, p1, p2);
            apply(mid, head, n, f);
            step(64);
            check($sformatf("rnd%0d_pass1", r), bus.shaOutput, p1);
            step(64);
            check($sformatf("rnd%0d_pass2", r), bus.shaOutput, p2);
            check($sformatf("rnd%0d_core", r), bus.coreOutput, {(p2[31:0] == 32'h0), nsum});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sha_core_top.md
# sha_core_top

Iterative double-SHA-256 Bitcoin nonce tester: one compression round per clock, 64 rounds per pass, two passes per nonce. Pass 1 compresses the second header chunk (with the nonce substituted) starting from a precomputed midstate. Pass 2 hashes the 256-bit result again from the standard IV. Sits between the host interface (which supplies midState/headData/nonce) and the miner controller (which reads coreOutput).

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- clearCounter  in  1  reset; synchronous, active-high; clears counter, phase, hash and result registers
- solveEn  in  1  run enable; 1 = advance one round per clock, 0 = freeze all state
- midState  in  256  pass-1 chaining value; H0 at [255:224] … H7 at [31:0]
- headData  in  512  pass-1 message block; W0 at [31:0] … W15 at [511:480]
- nonce  in  32  base nonce
- nonceFactor  in  32  per-core offset added to nonce
- cycle  out  6  current round index 0..63
- shaOutput  out  256  hash register; H0 at [255:224]
- coreOutput  out  33  [32] golden flag, [31:0] nonce that produced it

## Operation
- Effective nonce N = nonce + nonceFactor, mod 2^32.
- N is latched at the start of each pass 1, when cycle==0 and phase==0.
- Pass 1 message:
  - Word 3 is replaced by byteswap(N), so N=0x1884958D gives W3=0x8D958418.
  - All other words come from headData.
  - Initial state is midState.
- Pass 2 message:
  - W0..W7 = pass-1 hash, with H0 as W0.
  - W8 = 0x80000000; W9..W14 = 0; W15 = 0x00000100.
  - Initial state is the standard SHA-256 IV (6a09e667 … 5be0cd19).
- Round t on each pass:
  - Uses standard Ch, Maj, Σ0, Σ1, σ0, σ1 and constant K[t]; all additions are mod 2^32.
  - At t=0 the working variables a..h and the 16-word schedule window are taken from the pass's initial state and message, through a combinational mux.
  - Each round shifts the schedule window by one word, appending W[t+16].
- At the end of round 63, hash = initial state + a..h, word by word.
  - The hash is written to shaOutput and phase toggles.
- At the end of pass 2:
  - coreOutput[31:0] = latched N.
  - coreOutput[32] = 1 iff final H7 == 32'h0, otherwise 0.
  - coreOutput holds until the next pass-2 completion.
- solveEn=0 freezes everything; resuming continues from the frozen round.

## Timing
- Reset (clearCounter=1 at a rising edge): cycle=0, phase=0, a..h=0, schedule=0, shaOutput=0, coreOutput=0. Reset wins over solveEn.
- Counter: increments on every enabled edge; 63 wraps to 0.
- Latency:
  - Pass-1 hash appears on shaOutput 64 enabled edges after the first enabled edge with cycle==0.
  - The final hash and coreOutput appear 128 enabled edges after that edge.
- Nonce changes mid-pass have no effect until the next pass 1.
- Changes to midState/headData are sampled only at t=0 of pass 1; they must be stable on that edge.
- Reset mid-pass aborts the pass; coreOutput returns to 0.

## Structure
- Shared package sha_pkg: K[0:63] constant array, IV constant, and functions ch, maj, big_sigma0/1, small_sigma0/1, byteswap32.
- Sub-module cycle_counter (clk, clearCounter, solveEn → cycle[5:0]) is instantiated in the top.
- The round datapath, schedule window, phase bit and result registers live in the top.

## Test plan
- Reset/counter:
  - Assert clearCounter for 1 cycle -> cycle=0, shaOutput=0, coreOutput=0.
  - Then solveEn=1 for 64 edges -> cycle reads 0,1,…,63,0.
- Freeze: drop solveEn at cycle=20 for 5 clocks -> cycle and shaOutput unchanged; resuming yields the same final hash as an uninterrupted run.
- Nonce insertion:
  - Stimulus: nonce=411342221, nonceFactor=0, midState=283048996015d72e781f50c06df10eb3bda2b4ea48f552d85a018aef1e397ddc.
  - headData W0..W2 = 7dab00c4, 76167e54, 61481b18; W4=80000000; W15=00000280.
  - Required: pass-1 W3 = 8d958418.
  - shaOutput after 64 and 128 edges must match a software double-SHA-256 model.
- Offset: same vector with nonce=411342220, nonceFactor=1 -> identical shaOutput and coreOutput[31:0]=0x1884958D.
- Golden flag:
  - Drive a vector whose software-model final H7 is 0 -> coreOutput[32]=1 at edge 128.
  - Drive any other vector -> coreOutput[32]=0.
- Reset mid-pass: assert clearCounter at cycle=40 of pass 2 -> all outputs 0 next edge; the rerun result matches the model.
